// File: rtl/mul_chain_pkg.sv
// Shared constants and FSM state type for the multiply-chain block accumulator.
package mul_chain_pkg;

    localparam int unsigned PROD_W    = 32;
    localparam int unsigned ACC_W_DEF = 40;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/mul_chain_acc_sat_add.sv
// Combinational saturating adder: ACC_W accumulator plus 32-bit unsigned addend,
// pinned at all-ones once an overflow has occurred (sticky-in) or occurs now.
module sat_add
    import mul_chain_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] addend,
    input  logic              sticky_in,
    output logic [ACC_W-1:0]  sum_out,
    output logic              ovf_out
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum     = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        ovf_out = sum[ACC_W] | sticky_in;
        sum_out = ovf_out ? '1 : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/mul_chain_acc.sv
// Block accumulator behind the multiply chain: sums products per in_last-delimited
// block with saturation, and presents each block on a one-entry valid/ready slot.
module mul_chain_acc
    import mul_chain_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [31:0]       y_in,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               beat_acc;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   acc_new;
    logic               ovf_new;
    logic [CNT_W-1:0]   cnt_new;

    // In IDLE the adder starts from zero, so a block never inherits stale state.
    assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc_in    (acc_base),
        .addend    (y_in),
        .sticky_in (ovf_q),
        .sum_out   (acc_new),
        .ovf_out   (ovf_new)
    );

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        beat_acc    = in_valid && in_ready;
        cnt_new     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (beat_acc) begin
            if (in_last) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_new;
                out_count_d = cnt_new;
                out_ovf_d   = ovf_new;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                state_d     = ST_IDLE;
            end else begin
                acc_d       = acc_new;
                cnt_d       = cnt_new;
                ovf_d       = ovf_new;
                state_d     = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul_chain_acc.sv
// Bench for mul_chain_acc: three parameterisations share one stimulus stream and
// are checked every cycle against a block-level model plus directed literals.
module tb_mul_chain_acc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] y_in;
    logic        in_last;
    logic        out_ready;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [39:0] d0;
    logic [32:0] d1;
    logic [39:0] d2;
    logic [7:0]  c0, c1;
    logic [1:0]  c2;
    logic        of0, of1, of2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_chain_acc #(.ACC_W(40), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .y_in(y_in), .in_last(in_last),
        .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready), .out_data(d0),
        .out_count(c0), .out_ovf(of0));

    mul_chain_acc #(.ACC_W(33), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .y_in(y_in), .in_last(in_last),
        .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready), .out_data(d1),
        .out_count(c1), .out_ovf(of1));

    mul_chain_acc #(.ACC_W(40), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .y_in(y_in), .in_last(in_last),
        .in_ready(ir2), .out_valid(ov2), .out_ready(out_ready), .out_data(d2),
        .out_count(c2), .out_ovf(of2));

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [64:0] acc_max(input int i);
        return (i == 1) ? ((65'd1 << 33) - 65'd1) : ((65'd1 << 40) - 65'd1);
    endfunction

    function automatic int unsigned cnt_max(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    // Model: open-block sum/count/overflow and slot contents, per instance.
    logic [64:0] m_acc  [3];
    int unsigned m_cnt  [3];
    logic        m_ovf  [3];
    logic        e_valid[3];
    logic [64:0] e_data [3];
    int unsigned e_cnt  [3];
    logic        e_ovf  [3];

    always @(posedge clk or negedge reset_n) begin
        logic        rdy;
        logic [64:0] nacc;
        logic        novf;
        int unsigned ncnt;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_acc[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
                e_valid[i] = 1'b0; e_data[i] = '0; e_cnt[i] = 0; e_ovf[i] = 1'b0;
            end else begin
                rdy = !e_valid[i] || out_ready;
                if (e_valid[i] && out_ready) e_valid[i] = 1'b0;
                if (in_valid && rdy) begin
                    nacc = m_acc[i] + 65'(y_in);
                    novf = m_ovf[i];
                    if (novf || nacc > acc_max(i)) begin
                        nacc = acc_max(i);
                        novf = 1'b1;
                    end
                    ncnt = (m_cnt[i] + 1 > cnt_max(i)) ? cnt_max(i) : m_cnt[i] + 1;
                    if (in_last) begin
                        e_valid[i] = 1'b1; e_data[i] = nacc; e_cnt[i] = ncnt; e_ovf[i] = novf;
                        m_acc[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
                    end else begin
                        m_acc[i] = nacc; m_cnt[i] = ncnt; m_ovf[i] = novf;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        av, ar, ao;
        logic [64:0] ad;
        logic [31:0] ac;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin av = ov0; ar = ir0; ad = 65'(d0); ac = 32'(c0); ao = of0; end
                1:       begin av = ov1; ar = ir1; ad = 65'(d1); ac = 32'(c1); ao = of1; end
                default: begin av = ov2; ar = ir2; ad = 65'(d2); ac = 32'(c2); ao = of2; end
            endcase
            chk($sformatf("m%0d_out_valid", i), 65'(av), 65'(e_valid[i]));
            chk($sformatf("m%0d_in_ready", i), 65'(ar), 65'(!e_valid[i] || out_ready));
            if (e_valid[i]) begin
                chk($sformatf("m%0d_out_data", i), ad, e_data[i]);
                chk($sformatf("m%0d_out_count", i), 65'(ac), 65'(e_cnt[i]));
                chk($sformatf("m%0d_out_ovf", i), 65'(ao), 65'(e_ovf[i]));
            end
        end
    end

    task automatic send(input logic [31:0] y, input logic last);
        in_valid = 1'b1;
        y_in     = y;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        y_in     = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 65'(ov0), 65'd0);
        chk("rst_out_data", 65'(d0), 65'd0);
        chk("rst_out_count", 65'(c0), 65'd0);
        chk("rst_out_ovf", 65'(of0), 65'd0);
        chk("rst_in_ready", 65'(ir0), 65'd1);
        reset_n = 1'b1;
        idle_cycle();

        // Basic block
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b1);
        chk("basic_valid", 65'(ov0), 65'd1);
        chk("basic_data", 65'(d0), 65'd60);
        chk("basic_count", 65'(c0), 65'd3);
        chk("basic_ovf", 65'(of0), 65'd0);

        // Saturation on the 33-bit instance; 40-bit instance holds the true sum
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        chk("sat_data", 65'(d1), 65'h1_FFFF_FFFF);
        chk("sat_ovf", 65'(of1), 65'd1);
        chk("sat_count", 65'(c1), 65'd3);
        chk("nosat_data", 65'(d0), 65'h2_FFFF_FFFD);
        chk("nosat_ovf", 65'(of0), 65'd0);
        send(32'd4, 1'b1);
        chk("post_sat_data", 65'(d1), 65'd4);
        chk("post_sat_ovf", 65'(of1), 65'd0);

        // Back-to-back blocks
        send(32'd1, 1'b0);
        send(32'd2, 1'b1);
        chk("b2b_first_data", 65'(d0), 65'd3);
        chk("b2b_first_count", 65'(c0), 65'd2);
        send(32'd7, 1'b1);
        chk("b2b_second_data", 65'(d0), 65'd7);
        chk("b2b_second_count", 65'(c0), 65'd1);
        chk("b2b_second_valid", 65'(ov0), 65'd1);

        // Zero-valued single-beat block
        send(32'd0, 1'b1);
        chk("zero_data", 65'(d0), 65'd0);
        chk("zero_count", 65'(c0), 65'd1);
        chk("zero_valid", 65'(ov0), 65'd1);

        // Count saturation on the CNT_W=2 instance
        for (int i = 0; i < 6; i++) send(32'd1, (i == 5));
        chk("cntsat_count", 65'(c2), 65'd3);
        chk("cntsat_data", 65'(d2), 65'd6);
        chk("cnt_wide_count", 65'(c0), 65'd6);

        // Backpressure
        idle_cycle();
        chk("drained_valid", 65'(ov0), 65'd0);
        out_ready = 1'b0;
        send(32'd5, 1'b1);
        chk("bp_valid", 65'(ov0), 65'd1);
        chk("bp_data", 65'(d0), 65'd5);
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            chk("bp_hold_in_ready", 65'(ir0), 65'd0);
            chk("bp_hold_data", 65'(d0), 65'd5);
            chk("bp_hold_valid", 65'(ov0), 65'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 65'(ir0), 65'd1);
        send(32'd9, 1'b1);
        chk("bp_reload_valid", 65'(ov0), 65'd1);
        chk("bp_reload_data", 65'(d0), 65'd9);
        chk("bp_reload_count", 65'(c0), 65'd1);

        // Reset mid-block
        idle_cycle();
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 65'(ov0), 65'd0);
        chk("midrst_data", 65'(d0), 65'd0);
        chk("midrst_count", 65'(c0), 65'd0);
        chk("midrst_ovf", 65'(of0), 65'd0);
        chk("midrst_in_ready", 65'(ir0), 65'd1);
        idle_cycle();
        reset_n = 1'b1;
        idle_cycle();
        send(32'd5, 1'b1);
        chk("after_rst_data", 65'(d0), 65'd5);
        chk("after_rst_count", 65'(c0), 65'd1);
        chk("after_rst_valid", 65'(ov0), 65'd1);

        repeat (3) idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
